// File: rtl/psljobsequencer_if.sv
// Job-sequencer bus: MMIO job setup/status plus the PSL read/write command and completion signals.
// master = sequencer side, slave = MMIO/PSL/core environment side.
interface psljobsequencer_if #(
  parameter int TAG_WIDTH = 5
);
  logic                 start_pls;
  logic [63:0]          read_base_addr;
  logic [63:0]          write_base_addr;
  logic [31:0]          num_items_to_process;
  logic                 rd_cmd_valid;
  logic                 rd_cmd_ready;
  logic [63:0]          rd_cmd_addr;
  logic [TAG_WIDTH-1:0] rd_cmd_tag;
  logic                 rd_resp_valid;
  logic                 res_valid;
  logic                 res_ready;
  logic [63:0]          wr_cmd_addr;
  logic [TAG_WIDTH-1:0] wr_cmd_tag;
  logic                 wr_resp_valid;
  logic [31:0]          num_reads_read_active;
  logic [31:0]          num_reads_written_active;
  logic                 busy;
  logic                 finish;

  modport master (
    input  start_pls, read_base_addr, write_base_addr, num_items_to_process,
    input  rd_cmd_ready, rd_resp_valid, res_valid, wr_resp_valid,
    output rd_cmd_valid, rd_cmd_addr, rd_cmd_tag, res_ready, wr_cmd_addr, wr_cmd_tag,
    output num_reads_read_active, num_reads_written_active, busy, finish
  );

  modport slave (
    output start_pls, read_base_addr, write_base_addr, num_items_to_process,
    output rd_cmd_ready, rd_resp_valid, res_valid, wr_resp_valid,
    input  rd_cmd_valid, rd_cmd_addr, rd_cmd_tag, res_ready, wr_cmd_addr, wr_cmd_tag,
    input  num_reads_read_active, num_reads_written_active, busy, finish
  );
endinterface

// File: rtl/psljobsequencer.sv
// Issues one PSL read per item, then one write per core result, each under its own tag-credit window.
//
// state | meaning
// IDLE  | waiting for start_pls; counts of the last job stay visible
// RUN   | issuing reads/writes and collecting completions
// DONE  | single-cycle finish pulse, then back to IDLE
module psljobsequencer #(
  parameter int LINE_BYTES = 128,
  parameter int MAX_TAGS   = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rstb,
  psljobsequencer_if.master bus
);
  localparam int          LINE_SHIFT = $clog2(LINE_BYTES);
  localparam logic [31:0] MAX_OUT    = 32'(MAX_TAGS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [63:0] rd_base_q, rd_base_d, wr_base_q, wr_base_d;
  logic [31:0] n_q, n_d;
  logic [31:0] rd_issued_q, rd_issued_d, wr_issued_q, wr_issued_d;
  logic [31:0] rd_out_q, rd_out_d, wr_out_q, wr_out_d;
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic        busy_q, busy_d, finish_q, finish_d;

  logic rd_cmd_valid, res_ready, rd_acc, wr_acc, rd_rsp, wr_rsp, done_cond, running;

  assign running      = (state_q == RUN);
  assign rd_cmd_valid = running && (rd_issued_q < n_q) && (rd_out_q < MAX_OUT);
  assign res_ready    = running && (wr_issued_q < rd_cnt_q) && (wr_out_q < MAX_OUT);
  assign rd_acc       = rd_cmd_valid && bus.rd_cmd_ready;
  assign wr_acc       = res_ready && bus.res_valid;
  // A completion with nothing outstanding is stray and must not move any counter.
  assign rd_rsp       = running && bus.rd_resp_valid && (rd_out_q != '0);
  assign wr_rsp       = running && bus.wr_resp_valid && (wr_out_q != '0);
  assign done_cond    = (rd_issued_q == n_q) && (rd_cnt_q == n_q) &&
                        (wr_issued_q == n_q) && (wr_cnt_q == n_q);

  always_comb begin
    state_d     = state_q;
    rd_base_d   = rd_base_q;
    wr_base_d   = wr_base_q;
    n_d         = n_q;
    rd_issued_d = rd_issued_q;
    wr_issued_d = wr_issued_q;
    rd_out_d    = rd_out_q;
    wr_out_d    = wr_out_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start_pls) begin
          state_d     = RUN;
          rd_base_d   = bus.read_base_addr;
          wr_base_d   = bus.write_base_addr;
          n_d         = bus.num_items_to_process;
          rd_issued_d = '0;
          wr_issued_d = '0;
          rd_out_d    = '0;
          wr_out_d    = '0;
          rd_cnt_d    = '0;
          wr_cnt_d    = '0;
        end
      end
      RUN: begin
        if (rd_acc) rd_issued_d = rd_issued_q + 32'd1;
        if (wr_acc) wr_issued_d = wr_issued_q + 32'd1;
        case ({rd_acc, rd_rsp})
          2'b10:   rd_out_d = rd_out_q + 32'd1;
          2'b01:   rd_out_d = rd_out_q - 32'd1;
          default: rd_out_d = rd_out_q;
        endcase
        case ({wr_acc, wr_rsp})
          2'b10:   wr_out_d = wr_out_q + 32'd1;
          2'b01:   wr_out_d = wr_out_q - 32'd1;
          default: wr_out_d = wr_out_q;
        endcase
        if (rd_rsp && (rd_cnt_q < n_q)) rd_cnt_d = rd_cnt_q + 32'd1;
        if (wr_rsp && (wr_cnt_q < n_q)) wr_cnt_d = wr_cnt_q + 32'd1;
        if (done_cond) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!soft_rstb) begin
      state_d     = IDLE;
      rd_base_d   = '0;
      wr_base_d   = '0;
      n_d         = '0;
      rd_issued_d = '0;
      wr_issued_d = '0;
      rd_out_d    = '0;
      wr_out_d    = '0;
      rd_cnt_d    = '0;
      wr_cnt_d    = '0;
    end

    busy_d   = (state_d == RUN);
    finish_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_base_q   <= '0;
      wr_base_q   <= '0;
      n_q         <= '0;
      rd_issued_q <= '0;
      wr_issued_q <= '0;
      rd_out_q    <= '0;
      wr_out_q    <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_base_q   <= rd_base_d;
      wr_base_q   <= wr_base_d;
      n_q         <= n_d;
      rd_issued_q <= rd_issued_d;
      wr_issued_q <= wr_issued_d;
      rd_out_q    <= rd_out_d;
      wr_out_q    <= wr_out_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
    end
  end

  assign bus.rd_cmd_valid             = rd_cmd_valid;
  assign bus.rd_cmd_addr              = rd_base_q + (64'(rd_issued_q) << LINE_SHIFT);
  assign bus.rd_cmd_tag               = rd_issued_q[TAG_WIDTH-1:0];
  assign bus.res_ready                = res_ready;
  assign bus.wr_cmd_addr              = wr_base_q + (64'(wr_issued_q) << LINE_SHIFT);
  assign bus.wr_cmd_tag               = wr_issued_q[TAG_WIDTH-1:0];
  assign bus.num_reads_read_active    = rd_cnt_q;
  assign bus.num_reads_written_active = wr_cnt_q;
  assign bus.busy                     = busy_q;
  assign bus.finish                   = finish_q;
endmodule

// File: tb/tb_psljobsequencer.sv
// Directed bench for psljobsequencer: a job table plus hand-written multi-cycle sequences,
// with a delayed-completion responder and a command monitor that checks every address and tag.
module tb_psljobsequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic soft_rstb = 1'b1;
  always #5 clk = ~clk;

  psljobsequencer_if #(.TAG_WIDTH(5)) bus ();
  psljobsequencer #(.LINE_BYTES(128), .MAX_TAGS(32), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .soft_rstb(soft_rstb), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // environment state shared by responder and monitor
  int          cyc = 0;
  int          rd_delay = 3;
  bit          rd_hold = 1'b0;
  int          rd_grant = 0;
  int          rd_q[$];
  int          wr_q[$];
  int          rd_acc_n = 0;
  int          wr_acc_n = 0;
  int          fin_n = 0;
  logic [63:0] exp_rb = '0;
  logic [63:0] exp_wb = '0;
  logic [63:0] last_rd = '0;
  logic [63:0] last_wr = '0;

  // responder: completions driven just after the active edge
  initial begin
    bus.rd_resp_valid = 1'b0;
    bus.wr_resp_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.rd_resp_valid = 1'b0;
      bus.wr_resp_valid = 1'b0;
      if (rd_q.size() > 0 && rd_q[0] <= cyc && (!rd_hold || rd_grant > 0)) begin
        bus.rd_resp_valid = 1'b1;
        rd_q.delete(0);
        if (rd_hold) rd_grant--;
      end
      if (wr_q.size() > 0 && wr_q[0] <= cyc) begin
        bus.wr_resp_valid = 1'b1;
        wr_q.delete(0);
      end
    end
  end

  // monitor: sampled mid-cycle, sees exactly what the next edge will see
  initial begin
    forever begin
      @(negedge clk);
      if (bus.start_pls && !bus.busy && !bus.finish && soft_rstb && !rst) begin
        rd_acc_n = 0;
        wr_acc_n = 0;
        fin_n    = 0;
        exp_rb   = bus.read_base_addr;
        exp_wb   = bus.write_base_addr;
      end
      if (bus.rd_cmd_valid && bus.rd_cmd_ready) begin
        check("rd_addr", bus.rd_cmd_addr, exp_rb + 64'(rd_acc_n) * 64'd128);
        check("rd_tag", 64'(bus.rd_cmd_tag), 64'(rd_acc_n % 32));
        last_rd = bus.rd_cmd_addr;
        rd_acc_n++;
        rd_q.push_back(cyc + rd_delay);
      end
      if (bus.res_valid && bus.res_ready) begin
        check("wr_addr", bus.wr_cmd_addr, exp_wb + 64'(wr_acc_n) * 64'd128);
        check("wr_tag", 64'(bus.wr_cmd_tag), 64'(wr_acc_n % 32));
        last_wr = bus.wr_cmd_addr;
        wr_acc_n++;
        wr_q.push_back(cyc + rd_delay);
      end
      if (bus.finish) fin_n++;
    end
  end

  task automatic start_job(input logic [31:0] n, input logic [63:0] rb, input logic [63:0] wb);
    @(posedge clk);
    #1;
    bus.num_items_to_process = n;
    bus.read_base_addr       = rb;
    bus.write_base_addr      = wb;
    bus.start_pls            = 1'b1;
    @(posedge clk);
    #1;
    bus.start_pls = 1'b0;
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fin_n > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_job_end(input string tag, input int n, input logic [63:0] lrd,
                               input logic [63:0] lwr);
    bit ok;
    wait_finish(3000, ok);
    check({tag, "_finish_seen"}, 64'(ok), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_finish_once"}, 64'(fin_n), 64'd1);
    check({tag, "_rd_issued"}, 64'(rd_acc_n), 64'(n));
    check({tag, "_wr_issued"}, 64'(wr_acc_n), 64'(n));
    check({tag, "_rd_count"}, 64'(bus.num_reads_read_active), 64'(n));
    check({tag, "_wr_count"}, 64'(bus.num_reads_written_active), 64'(n));
    check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    if (n > 0) begin
      check({tag, "_last_rd"}, last_rd, lrd);
      check({tag, "_last_wr"}, last_wr, lwr);
    end
  endtask

  typedef struct {
    logic [31:0] n;
    logic [63:0] rb;
    logic [63:0] wb;
    int          dly;
    logic [63:0] last_rd;
    logic [63:0] last_wr;
  } job_t;

  job_t jobs[4];

  initial begin
    int k;
    bus.start_pls            = 1'b0;
    bus.read_base_addr       = '0;
    bus.write_base_addr      = '0;
    bus.num_items_to_process = '0;
    bus.rd_cmd_ready         = 1'b1;
    bus.res_valid            = 1'b1;

    jobs[0] = '{32'd4,  64'h1000,                64'h8000,     3, 64'h1180,                64'h8180};
    jobs[1] = '{32'd1,  64'hFFFF_FFFF_FFFF_FF80, 64'h0,        1, 64'hFFFF_FFFF_FFFF_FF80, 64'h0};
    jobs[2] = '{32'd3,  64'hFFFF_FFFF_FFFF_FF00, 64'h40,       5, 64'h0,                   64'h140};
    jobs[3] = '{32'd40, 64'h0,                   64'h10_0000,  2, 64'h1380,                64'h10_1380};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_finish", 64'(bus.finish), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_cmd_valid), 64'd0);
    check("rst_res_ready", 64'(bus.res_ready), 64'd0);
    check("rst_rd_count", 64'(bus.num_reads_read_active), 64'd0);
    check("rst_wr_count", 64'(bus.num_reads_written_active), 64'd0);
    check("rst_rd_addr", bus.rd_cmd_addr, 64'd0);

    for (int i = 0; i < 4; i++) begin
      rd_delay = jobs[i].dly;
      start_job(jobs[i].n, jobs[i].rb, jobs[i].wb);
      check_job_end($sformatf("job%0d", i), int'(jobs[i].n), jobs[i].last_rd, jobs[i].last_wr);
    end

    // empty job: one RUN cycle, finish two cycles after start
    start_job(32'd0, 64'h1234_0000, 64'h5678_0000);
    @(negedge clk);
    check("n0_busy_run", 64'(bus.busy), 64'd1);
    check("n0_finish_run", 64'(bus.finish), 64'd0);
    check("n0_rd_valid", 64'(bus.rd_cmd_valid), 64'd0);
    check("n0_res_ready", 64'(bus.res_ready), 64'd0);
    @(negedge clk);
    check("n0_busy_done", 64'(bus.busy), 64'd0);
    check("n0_finish_done", 64'(bus.finish), 64'd1);
    @(negedge clk);
    check("n0_finish_low", 64'(bus.finish), 64'd0);
    check("n0_finish_once", 64'(fin_n), 64'd1);
    check("n0_no_cmds", 64'(rd_acc_n + wr_acc_n), 64'd0);
    check("n0_rd_count", 64'(bus.num_reads_read_active), 64'd0);

    // credit window: read completions withheld
    rd_hold  = 1'b1;
    rd_grant = 0;
    rd_delay = 2;
    start_job(32'd40, 64'h2_0000, 64'h3_0000);
    repeat (45) @(negedge clk);
    check("cred_issued32", 64'(rd_acc_n), 64'd32);
    check("cred_valid_low", 64'(bus.rd_cmd_valid), 64'd0);
    check("cred_res_ready", 64'(bus.res_ready), 64'd0);
    rd_grant = 1;
    repeat (8) @(negedge clk);
    check("cred_issued33", 64'(rd_acc_n), 64'd33);
    check("cred_valid_low2", 64'(bus.rd_cmd_valid), 64'd0);
    check("cred_rd_count1", 64'(bus.num_reads_read_active), 64'd1);
    rd_hold = 1'b0;
    check_job_end("cred", 40, 64'h2_0000 + 64'd39 * 64'd128, 64'h3_0000 + 64'd39 * 64'd128);

    // backpressure: command must hold steady while not accepted
    rd_delay = 3;
    @(posedge clk);
    #1 bus.rd_cmd_ready = 1'b0;
    start_job(32'd2, 64'h5000, 64'h6000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(bus.rd_cmd_valid), 64'd1);
      check("bp_addr", bus.rd_cmd_addr, 64'h5000);
      check("bp_tag", 64'(bus.rd_cmd_tag), 64'd0);
      check("bp_no_issue", 64'(rd_acc_n), 64'd0);
    end
    @(posedge clk);
    #1 bus.rd_cmd_ready = 1'b1;
    check_job_end("bp", 2, 64'h5080, 64'h6080);

    // start_pls during RUN is ignored
    start_job(32'd8, 64'hA000, 64'hB000);
    k = 0;
    while (rd_acc_n < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("mid_reached3", 64'(rd_acc_n >= 3), 64'd1);
    start_job(32'd2, 64'hC000_0000, 64'hD000_0000);
    check_job_end("mid", 8, 64'hA380, 64'hB380);

    // soft reset abandons the job silently
    start_job(32'd20, 64'h7000, 64'h9000);
    k = 0;
    while (rd_acc_n < 5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("srst_reached5", 64'(rd_acc_n >= 5), 64'd1);
    @(posedge clk);
    #1 soft_rstb = 1'b0;
    @(posedge clk);
    #1 soft_rstb = 1'b1;
    @(negedge clk);
    check("srst_busy", 64'(bus.busy), 64'd0);
    check("srst_rd_count", 64'(bus.num_reads_read_active), 64'd0);
    check("srst_wr_count", 64'(bus.num_reads_written_active), 64'd0);
    check("srst_rd_valid", 64'(bus.rd_cmd_valid), 64'd0);
    check("srst_res_ready", 64'(bus.res_ready), 64'd0);
    repeat (15) @(negedge clk);
    check("srst_no_finish", 64'(fin_n), 64'd0);
    check("srst_idle", 64'(bus.busy), 64'd0);
    start_job(32'd2, 64'h7000, 64'h9000);
    check_job_end("srst_new", 2, 64'h7080, 64'h9080);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
